// File: rtl/pwm_multi_channel_if.sv
// Word-addressed register bus between the CPU and pwm_multi_channel.
// The master drives address, data and strobes; the slave returns registered read data.
interface pwm_multi_channel_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [4:0]           busAddr;
    logic [CNT_WIDTH-1:0] busWdata;
    logic                 busWe;
    logic                 busRe;
    logic [CNT_WIDTH-1:0] busRdata;

    modport master (output busAddr, busWdata, busWe, busRe, input busRdata);
    modport slave  (input busAddr, busWdata, busWe, busRe, output busRdata);
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel double-buffered duty.
// Optional centre-aligned counting is built only when PWM_CENTER_ALIGNED_EN is defined.
module pwm_multi_channel #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned PSC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    pwm_multi_channel_if.slave  bus,
    output logic [CHANNELS-1:0] pwmOut,
    output logic                periodIrq
);
    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_PRESC  = 5'h01;
    localparam logic [4:0] ADDR_PERIOD = 5'h02;
    localparam logic [4:0] ADDR_CHEN   = 5'h03;
    localparam logic [4:0] ADDR_POL    = 5'h04;
    localparam logic [4:0] ADDR_CNT    = 5'h05;
    localparam logic [4:0] ADDR_DUTY   = 5'h10;

    logic                 en_q, en_d;
`ifdef PWM_CENTER_ALIGNED_EN
    logic                 centre_q, centre_d;
    logic                 down_q, down_d;
`endif
    logic [PSC_WIDTH-1:0] presc_q, presc_d, psc_q, psc_d;
    logic [CNT_WIDTH-1:0] period_q, period_d, act_period_q, act_period_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, rdata_q, rdata_d;
    logic [CHANNELS-1:0]  chen_q, chen_d, pol_q, pol_d, pwm_q, pwm_d;
    logic [CNT_WIDTH-1:0] duty_q [CHANNELS];
    logic [CNT_WIDTH-1:0] duty_d [CHANNELS];
    logic [CNT_WIDTH-1:0] act_duty_q [CHANNELS];
    logic [CNT_WIDTH-1:0] act_duty_d [CHANNELS];
    logic                 irq_q, irq_d;
    logic                 tick, update;

    // Register file writes and registered read mux (reads see pre-write values)
    always_comb begin
        en_d     = en_q;
`ifdef PWM_CENTER_ALIGNED_EN
        centre_d = centre_q;
`endif
        presc_d  = presc_q;
        period_d = period_q;
        chen_d   = chen_q;
        pol_d    = pol_q;
        duty_d   = duty_q;
        rdata_d  = rdata_q;
        if (bus.busWe) begin
            case (bus.busAddr)
                ADDR_CTRL: begin
                    en_d = bus.busWdata[0];
`ifdef PWM_CENTER_ALIGNED_EN
                    centre_d = bus.busWdata[1];
`endif
                end
                ADDR_PRESC:  presc_d  = bus.busWdata[PSC_WIDTH-1:0];
                ADDR_PERIOD: period_d = bus.busWdata;
                ADDR_CHEN:   chen_d   = bus.busWdata[CHANNELS-1:0];
                ADDR_POL:    pol_d    = bus.busWdata[CHANNELS-1:0];
                default: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (bus.busAddr == ADDR_DUTY + 5'(i)) duty_d[i] = bus.busWdata;
                    end
                end
            endcase
        end
        if (bus.busRe) begin
            rdata_d = '0;
            case (bus.busAddr)
`ifdef PWM_CENTER_ALIGNED_EN
                ADDR_CTRL:   rdata_d = CNT_WIDTH'({centre_q, en_q});
`else
                ADDR_CTRL:   rdata_d = CNT_WIDTH'(en_q);
`endif
                ADDR_PRESC:  rdata_d = CNT_WIDTH'(presc_q);
                ADDR_PERIOD: rdata_d = period_q;
                ADDR_CHEN:   rdata_d = CNT_WIDTH'(chen_q);
                ADDR_POL:    rdata_d = CNT_WIDTH'(pol_q);
                ADDR_CNT:    rdata_d = cnt_q;
                default: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (bus.busAddr == ADDR_DUTY + 5'(i)) rdata_d = duty_q[i];
                    end
                end
            endcase
        end
    end

    // Prescaler, period counter and shadow-to-active transfer
    always_comb begin
        psc_d        = psc_q;
        cnt_d        = cnt_q;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        tick         = 1'b0;
        update       = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        down_d       = down_q;
`endif
        if (!en_q) begin
            psc_d        = '0;
            cnt_d        = '0;
            act_period_d = period_q;
            act_duty_d   = duty_q;
`ifdef PWM_CENTER_ALIGNED_EN
            down_d       = 1'b0;
`endif
        end else begin
            tick  = (psc_q == presc_q);
            // A PRESC write below the running psc wraps without producing a tick
            psc_d = (psc_q >= presc_q) ? '0 : psc_q + PSC_WIDTH'(1);
`ifdef PWM_CENTER_ALIGNED_EN
            if (!centre_q) down_d = 1'b0;
`endif
            if (tick) begin
`ifdef PWM_CENTER_ALIGNED_EN
                if (centre_q && down_q) begin
                    if (cnt_q == '0) begin
                        update = 1'b1;
                        cnt_d  = (period_q == '0) ? '0 : CNT_WIDTH'(1);
                        down_d = (period_q == '0);
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end else if (centre_q) begin
                    if (cnt_q >= act_period_q) begin
                        down_d = 1'b1;
                        cnt_d  = (cnt_q == '0) ? '0 : cnt_q - CNT_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else
`endif
                begin
                    if (cnt_q == act_period_q) begin
                        cnt_d  = '0;
                        update = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            if (update) begin
                act_period_d = period_q;
                act_duty_d   = duty_q;
            end
        end
    end

    // Channel outputs; disabled channels and a stopped timer sit at the POL idle level
    always_comb begin
        pwm_d = pol_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (en_q && chen_q[i]) pwm_d[i] = (cnt_q < act_duty_q[i]) ^ pol_q[i];
        end
        irq_d = update;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q         <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            centre_q     <= 1'b0;
            down_q       <= 1'b0;
`endif
            presc_q      <= '0;
            psc_q        <= '0;
            period_q     <= '0;
            act_period_q <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            chen_q       <= '0;
            pol_q        <= '0;
            pwm_q        <= '0;
            duty_q       <= '{default: '0};
            act_duty_q   <= '{default: '0};
            irq_q        <= 1'b0;
        end else begin
            en_q         <= en_d;
`ifdef PWM_CENTER_ALIGNED_EN
            centre_q     <= centre_d;
            down_q       <= down_d;
`endif
            presc_q      <= presc_d;
            psc_q        <= psc_d;
            period_q     <= period_d;
            act_period_q <= act_period_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            chen_q       <= chen_d;
            pol_q        <= pol_d;
            pwm_q        <= pwm_d;
            duty_q       <= duty_d;
            act_duty_q   <= act_duty_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.busRdata = rdata_q;
    assign pwmOut       = pwm_q;
    assign periodIrq    = irq_q;
endmodule
